// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, HMS field widths and bus packing for the stopwatch.
package stopwatch_pkg;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUNNING   = 2'd1,
    ST_PAUSED    = 2'd2,
    ST_SATURATED = 2'd3
  } state_t;
  localparam int HRS_W = 7;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int HMS_W = 20;
  function automatic logic [HMS_W-1:0] pack_hms(input logic [HRS_W-1:0] h, input logic [MIN_W-1:0] m,
                                                input logic [SEC_W-1:0] s);
    return {1'b0, h, m, s};
  endfunction
endpackage

// File: rtl/hms_counter.sv
// hms_counter: cascaded half_sec/min/hrs counter that holds at MAX_HRS:59:59 instead of wrapping.
module hms_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_HRS = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             tick,
  output logic             at_max,
  output logic [HMS_W-1:0] hms
);
  logic [6:0]       half_sec_q, half_sec_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [HRS_W-1:0] hrs_q, hrs_d;
  logic             inc, hs_wrap, min_wrap;
  assign at_max = hrs_q == HRS_W'(MAX_HRS) && min_q == 6'd59 && half_sec_q == 7'd119;
  assign hms    = pack_hms(hrs_q, min_q, half_sec_q[6:1]);
  always_comb begin
    inc        = en && tick && !at_max;
    hs_wrap    = half_sec_q == 7'd119;
    min_wrap   = min_q == 6'd59;
    half_sec_d = clr ? 7'd0 : inc ? (hs_wrap ? 7'd0 : half_sec_q + 7'd1) : half_sec_q;
    min_d      = clr ? 6'd0 : (inc && hs_wrap) ? (min_wrap ? 6'd0 : min_q + 6'd1) : min_q;
    hrs_d      = clr ? 7'd0 : (inc && hs_wrap && min_wrap) ? hrs_q + 7'd1 : hrs_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_sec_q <= '0;
      min_q      <= '0;
      hrs_q      <= '0;
    end else begin
      half_sec_q <= half_sec_d;
      min_q      <= min_d;
      hrs_q      <= hrs_d;
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear/lap FSM around an elapsed-time counter,
// with a timed lap snapshot multiplexed onto the display bus.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int LAP_HOLD_HS = 10,
  parameter int MAX_HRS     = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             half_sec_pulse,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             lap,
  output logic             run,
  output logic [1:0]       state,
  output logic [HMS_W-1:0] elapsed_hms,
  output logic [HMS_W-1:0] display_hms,
  output logic             lap_active,
  output logic             saturated
);
  localparam int HOLD_W = $clog2(LAP_HOLD_HS + 1);
  state_t           state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HMS_W-1:0] lap_q, lap_d;
  logic             at_max, lap_take;
  hms_counter #(.MAX_HRS(MAX_HRS)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .en    (state_q == ST_RUNNING),
    .tick  (half_sec_pulse),
    .at_max(at_max),
    .hms   (elapsed_hms)
  );
  always_comb begin
    lap_take = lap && !clear && !start_stop && (state_q == ST_RUNNING || state_q == ST_PAUSED);
    state_d  = clear ? ST_IDLE
             : start_stop ? (state_q == ST_RUNNING ? ST_PAUSED
                           : state_q == ST_SATURATED ? ST_SATURATED : ST_RUNNING)
             : (state_q == ST_RUNNING && half_sec_pulse && at_max) ? ST_SATURATED : state_q;
    // a fresh lap reloads the full hold even when a tick lands in the same cycle
    hold_d   = clear ? '0 : lap_take ? HOLD_W'(LAP_HOLD_HS)
             : (half_sec_pulse && hold_q != '0) ? hold_q - 1'b1 : hold_q;
    lap_d    = clear ? '0 : lap_take ? elapsed_hms : lap_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lap_q   <= lap_d;
    end
  end
  assign state       = state_q;
  assign run         = state_q == ST_RUNNING;
  assign saturated   = state_q == ST_SATURATED;
  assign lap_active  = hold_q != '0;
  assign display_hms = lap_active ? lap_q : elapsed_hms;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: table-driven vectors plus directed multi-cycle sequences for stopwatch_ctrl.
module tb_stopwatch_ctrl;
  logic        clk, rst_n, half_sec_pulse, start_stop, clear, lap;
  logic        run, lap_active, saturated;
  logic [1:0]  state;
  logic [19:0] elapsed_hms, display_hms;
  int          n_checks, n_fail;

  stopwatch_ctrl #(.LAP_HOLD_HS(10), .MAX_HRS(2)) dut (
    .clk(clk), .rst_n(rst_n), .half_sec_pulse(half_sec_pulse), .start_stop(start_stop),
    .clear(clear), .lap(lap), .run(run), .state(state), .elapsed_hms(elapsed_hms),
    .display_hms(display_hms), .lap_active(lap_active), .saturated(saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tick, ss, clr, lp;
    logic [1:0]  exp_state;
    logic [19:0] exp_elapsed;
    logic        exp_la;
    logic [19:0] exp_disp;
  } vec_t;

  function automatic logic [19:0] hms(input int h, input int m, input int s);
    logic [6:0] hh;
    logic [5:0] mm, ss6;
    hh = 7'(h);
    mm = 6'(m);
    ss6 = 6'(s);
    return {1'b0, hh, mm, ss6};
  endfunction

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic s, input logic c, input logic l);
    @(negedge clk);
    half_sec_pulse = t;
    start_stop = s;
    clear = c;
    lap = l;
    @(posedge clk);
    #1;
    half_sec_pulse = 0;
    start_stop = 0;
    clear = 0;
    lap = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1, 0, 0, 0);
  endtask

  vec_t vecs[14];

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 0;
    {half_sec_pulse, start_stop, clear, lap} = '0;
    //           tick ss clr lap  state elapsed        la disp
    vecs[0]  = '{1, 0, 0, 0, 2'd0, hms(0,0,0), 0, hms(0,0,0)};
    vecs[1]  = '{0, 0, 0, 1, 2'd0, hms(0,0,0), 0, hms(0,0,0)};
    vecs[2]  = '{0, 1, 0, 0, 2'd1, hms(0,0,0), 0, hms(0,0,0)};
    vecs[3]  = '{1, 0, 0, 0, 2'd1, hms(0,0,0), 0, hms(0,0,0)};
    vecs[4]  = '{1, 0, 0, 0, 2'd1, hms(0,0,1), 0, hms(0,0,1)};
    vecs[5]  = '{1, 1, 0, 0, 2'd2, hms(0,0,1), 0, hms(0,0,1)};
    vecs[6]  = '{1, 0, 0, 0, 2'd2, hms(0,0,1), 0, hms(0,0,1)};
    vecs[7]  = '{0, 0, 0, 1, 2'd2, hms(0,0,1), 1, hms(0,0,1)};
    vecs[8]  = '{1, 1, 0, 0, 2'd1, hms(0,0,1), 1, hms(0,0,1)};
    vecs[9]  = '{1, 0, 0, 0, 2'd1, hms(0,0,2), 1, hms(0,0,1)};
    vecs[10] = '{1, 0, 0, 1, 2'd1, hms(0,0,2), 1, hms(0,0,2)};
    vecs[11] = '{1, 0, 0, 0, 2'd1, hms(0,0,3), 1, hms(0,0,2)};
    vecs[12] = '{0, 1, 0, 1, 2'd2, hms(0,0,3), 1, hms(0,0,2)};
    vecs[13] = '{0, 1, 1, 1, 2'd0, hms(0,0,0), 0, hms(0,0,0)};

    repeat (2) @(negedge clk);
    chk("reset state", 20'(state), 20'd0);
    chk("reset run", 20'(run), 20'd0);
    chk("reset elapsed", elapsed_hms, 20'd0);
    chk("reset display", display_hms, 20'd0);
    chk("reset lap_active", 20'(lap_active), 20'd0);
    chk("reset saturated", 20'(saturated), 20'd0);
    rst_n = 1;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].tick, vecs[i].ss, vecs[i].clr, vecs[i].lp);
      chk($sformatf("row%0d state", i), 20'(state), 20'(vecs[i].exp_state));
      chk($sformatf("row%0d elapsed", i), elapsed_hms, vecs[i].exp_elapsed);
      chk($sformatf("row%0d lap_active", i), 20'(lap_active), 20'(vecs[i].exp_la));
      chk($sformatf("row%0d display", i), display_hms, vecs[i].exp_disp);
    end

    step(0, 1, 0, 0);
    chk("start run", 20'(run), 20'd1);
    ticks(120);
    chk("one minute", elapsed_hms, hms(0,1,0));
    chk("one minute state", 20'(state), 20'd1);
    step(0, 0, 1, 0);

    step(0, 1, 0, 0);
    ticks(5);
    step(1, 1, 0, 0);
    chk("pause sec", elapsed_hms, hms(0,0,3));
    chk("pause state", 20'(state), 20'd2);
    ticks(4);
    chk("paused frozen", elapsed_hms, hms(0,0,3));
    step(0, 0, 1, 0);

    step(0, 1, 0, 0);
    ticks(4);
    step(0, 0, 0, 1);
    ticks(9);
    chk("lap hold display", display_hms, hms(0,0,2));
    chk("lap hold active", 20'(lap_active), 20'd1);
    ticks(1);
    chk("lap expired active", 20'(lap_active), 20'd0);
    chk("lap expired display", display_hms, hms(0,0,7));
    step(0, 0, 1, 0);

    step(0, 1, 0, 0);
    ticks(7200);
    chk("hour carry", elapsed_hms, hms(1,0,0));
    ticks(14398);
    chk("near max", elapsed_hms, hms(2,59,59));
    ticks(1);
    chk("at max state", 20'(state), 20'd1);
    ticks(1);
    chk("sat state", 20'(state), 20'd3);
    chk("sat flag", 20'(saturated), 20'd1);
    ticks(1);
    chk("sat elapsed", elapsed_hms, hms(2,59,59));
    step(0, 1, 0, 0);
    chk("sat ignores ss", 20'(state), 20'd3);
    step(0, 0, 1, 0);
    chk("sat clear state", 20'(state), 20'd0);
    chk("sat clear elapsed", elapsed_hms, 20'd0);
    chk("sat clear flag", 20'(saturated), 20'd0);

    step(0, 1, 0, 0);
    ticks(3);
    step(0, 0, 0, 1);
    step(1, 1, 1, 1);
    chk("all3 state", 20'(state), 20'd0);
    chk("all3 elapsed", elapsed_hms, 20'd0);
    chk("all3 lap_active", 20'(lap_active), 20'd0);

    step(0, 1, 0, 0);
    ticks(5);
    step(0, 0, 0, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async state", 20'(state), 20'd0);
    chk("async run", 20'(run), 20'd0);
    chk("async elapsed", elapsed_hms, 20'd0);
    chk("async display", display_hms, 20'd0);
    chk("async lap_active", 20'(lap_active), 20'd0);
    @(negedge clk);
    rst_n = 1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("post reset tick", elapsed_hms, 20'd0);
    chk("post reset state", 20'(state), 20'd0);
    step(0, 1, 0, 0);
    ticks(2);
    chk("post reset count", elapsed_hms, hms(0,0,1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

- User-facing trip stopwatch controller. Sits downstream of the free-running half-second timebase.
- Sequences a gated elapsed-time counter from single-cycle button events: start/stop, clear and lap.
- Holds a lap snapshot and multiplexes live or lap time onto the display bus.
- Drives the run indicator and a saturation flag.

## Interface
- LAP_HOLD_HS, default 10: half-second ticks the lap snapshot stays on display_hms (10 = 5 s).
- MAX_HRS, default 99: hour value at which counting saturates.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset. All registers are cleared while it is low.
- half_sec_pulse  in  1  one-cycle tick every half second, from the timebase.
- start_stop  in  1  one-cycle, pre-debounced pulse that toggles run/pause.
- clear  in  1  one-cycle pulse that zeroes the stopwatch.
- lap  in  1  one-cycle pulse that captures a lap snapshot.
- run  out  1  high while state is RUNNING.
- state  out  2  0 IDLE, 1 RUNNING, 2 PAUSED, 3 SATURATED.
- elapsed_hms  out  20  live time as {1'b0, hrs[6:0], min[5:0], sec[5:0]}.
- display_hms  out  20  lap snapshot while the hold is active, otherwise elapsed_hms.
- lap_active  out  1  high while the lap snapshot is displayed.
- saturated  out  1  high in SATURATED.

## Operation
- The internal counter is half_sec 0..119, min 0..59, hrs 0..MAX_HRS. sec = half_sec >> 1.
- A tick advances the counter only when the registered state is RUNNING.
- half_sec 119 wraps to 0 and carries into min. min 59 wraps to 0 and carries into hrs.
- IDLE:
  - counter is zero.
  - start_stop goes to RUNNING.
  - lap is ignored.
- RUNNING:
  - start_stop goes to PAUSED.
  - A tick that would advance past MAX_HRS:59, half_sec 119 goes to SATURATED instead. The counter stays at MAX_HRS:59:59.
- PAUSED:
  - start_stop goes to RUNNING.
  - The counter is frozen.
- SATURATED:
  - start_stop is ignored.
  - Only clear exits.
- clear, from any state:
  - goes to IDLE.
  - zeroes the counter.
  - drops the lap hold.
- lap, in RUNNING or PAUSED:
  - copies elapsed_hms into the lap register.
  - reloads the hold counter with LAP_HOLD_HS and sets lap_active.
  - A lap during an active hold re-captures and reloads the hold counter.
- Hold countdown:
  - The hold counter decrements on every tick, in any state.
  - lap_active clears on the tick that takes the hold counter to 0.
- Simultaneous events:
  - Priority is clear > start_stop > lap. A lower-priority event in the same cycle is dropped.
  - Tick plus start_stop out of RUNNING: the tick is counted.
  - Tick plus start_stop into RUNNING: the tick is not counted.
  - Tick plus lap: the snapshot takes the pre-tick value, and the hold is loaded with the full LAP_HOLD_HS with no decrement.

## Timing
- Reset values:
  - state = IDLE, run = 0, saturated = 0, lap_active = 0.
  - elapsed_hms = 0, display_hms = 0.
  - Lap register and hold counter are 0.
- All outputs are registered, or are pure decodes of registered state.
- Latency:
  - Button pulse to state/run/lap_active change: 1 cycle.
  - Tick to elapsed_hms update: 1 cycle.
  - display_hms follows elapsed_hms or the lap register with no added cycle.
- Reset asserted mid-run clears everything immediately. Counting resumes only after a new start_stop.
- Pulses wider than one cycle are out of contract. Each high cycle counts as one event.

## Structure
- Package stopwatch_pkg holds:
  - the 2-bit state enum.
  - the HMS field widths (7/6/6) and the 20-bit HMS width.
  - a pack function producing the HMS bus.
- One sub-module, hms_counter:
  - cascaded half_sec/min/hrs counter.
  - inputs: enable, sync clear and tick.
  - outputs: an at_max flag and the packed HMS.
- stopwatch_ctrl holds the FSM, the lap register, the hold counter and the display mux.

## Test plan
- Reset low, then start_stop, then 120 ticks:
  - run = 1 one cycle after start_stop.
  - elapsed_hms = {0, 0, 1, 0} (0:01:00).
  - state = 1.
- Run 5 ticks, then start_stop in the same cycle as the 6th tick, then 4 more ticks:
  - sec = 3 (6 half-seconds).
  - state = 2.
  - elapsed is unchanged by the 4 ticks.
- Lap at 0:00:02, then 9 ticks:
  - display_hms holds 0:00:02 and lap_active = 1.
  - On the 10th tick lap_active = 0 and display_hms = elapsed_hms.
- Preload the counter to 99:59, half_sec 118 (via 2 ticks from a forced test path or a long run), then 3 ticks:
  - state = 3, saturated = 1.
  - elapsed = 99:59:59.
  - start_stop is ignored.
  - clear returns to IDLE with elapsed 0.
- clear, start_stop and lap asserted in the same cycle while RUNNING:
  - state = 0, elapsed = 0, lap_active = 0.
- Reset pulsed low mid-run, asynchronous to the clock:
  - all outputs are 0 before the next edge.
  - A tick after reset release does not count until start_stop.
